// File: rtl/sel_arb_mux_pkg.sv
// rtl/sel_arb_mux_pkg.sv - shared mode encodings and channel-id width helper
package sel_arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a channel-id field; at least one bit even for tiny channel counts.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sel_arb_mux_rr_arbiter.sv
// rtl/sel_arb_mux_rr_arbiter.sv - combinational round-robin arbiter (double-width rotate + priority pick)
module rr_arbiter
    import sel_arb_mux_pkg::*;
#(
    parameter  int NUM_CH = 6,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_gnt,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    int                  shamt;
    int                  offs;
    int                  idx;

    // Rotate requests so the channel after last_gnt sits at bit 0, pick the lowest set bit, map back.
    always_comb begin
        dbl        = {req, req};
        shamt      = (int'(last_gnt) + 1) % NUM_CH;
        rot        = '0;
        offs       = 0;
        gnt_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot[i] = dbl[i + shamt];
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = i;
            end
        end
        gnt_any = |rot;
        idx     = (shamt + offs) % NUM_CH;
        gnt_idx = CH_W'(idx);
        for (int i = 0; i < NUM_CH; i++) begin
            gnt_onehot[i] = gnt_any && (i == idx);
        end
    end

endmodule

// File: rtl/sel_arb_mux.sv
// rtl/sel_arb_mux.sv - N-channel selector with fixed/round-robin grant and registered valid/ready output
module sel_arb_mux
    import sel_arb_mux_pkg::*;
#(
    parameter  int NUM_CH = 6,
    parameter  int WIDTH  = 4,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rr_mode,
    input  logic [CH_W-1:0]         sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [CH_W-1:0]   last_gnt;
    logic [NUM_CH-1:0] arb_onehot;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;
    logic              load;
    logic              fx_hit;
    logic              gnt_any;
    logic [CH_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  gnt_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .req        (in_valid),
        .last_gnt   (last_gnt),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    // Grant selection: output register must be free, then FIXED or RR picks the channel.
    always_comb begin
        load     = !out_valid || out_ready;
        fx_hit   = 1'b0;
        gnt_data = '0;
        in_ready = '0;
        // Compare sel against each legal id so an out-of-range sel simply never matches.
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == CH_W'(i) && in_valid[i]) begin
                fx_hit = 1'b1;
            end
        end
        gnt_idx = (rr_mode == MODE_RR) ? arb_idx : sel;
        gnt_any = !reset && load && ((rr_mode == MODE_RR) ? arb_any : fx_hit);
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = gnt_any;
            end
        end
    end

    // Output register and round-robin pointer; pointer only moves on an RR transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last_gnt  <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data <= gnt_data;
                out_ch   <= gnt_idx;
                if (rr_mode == MODE_RR) begin
                    last_gnt <= gnt_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_sel_arb_mux.sv
// tb/tb_sel_arb_mux.sv - directed self-checking bench for sel_arb_mux
module tb_sel_arb_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        rr_mode;
    logic [2:0]  sel;
    logic [5:0]  in_valid;
    logic [23:0] in_data;
    logic [5:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    sel_arb_mux #(.NUM_CH(6), .WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rr_mode   (rr_mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_beat(input string tag, input int ch, input int data);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_ch"}, int'(out_ch), ch);
        check({tag, "_data"}, int'(out_data), data);
    endtask

    initial begin
        int exp_rr[7];
        int exp_sp[3];
        exp_rr = '{0, 1, 2, 3, 4, 5, 0};
        exp_sp = '{1, 4, 1};

        reset     = 1'b1;
        rr_mode   = 1'b1;
        sel       = 3'd0;
        in_valid  = 6'h3F;
        in_data   = 24'h543210;
        out_ready = 1'b1;

        // Reset held two cycles
        step();
        check("rst1_in_ready", int'(in_ready), 0);
        check("rst1_out_valid", int'(out_valid), 0);
        step();
        check("rst2_in_ready", int'(in_ready), 0);
        check("rst2_out_valid", int'(out_valid), 0);
        check("rst2_out_data", int'(out_data), 0);
        check("rst2_out_ch", int'(out_ch), 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 6'b000001);

        // RR full load, one beat per cycle
        for (int k = 0; k < 7; k++) begin
            step();
            expect_beat($sformatf("rr_full%0d", k), exp_rr[k], exp_rr[k]);
        end
        step();
        expect_beat("rr_full7", 1, 1);
        step();
        expect_beat("bp_load", 2, 2);

        // Backpressure for three cycles
        out_ready = 1'b0;
        #1;
        check("bp_in_ready0", int'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_beat($sformatf("bp_hold%0d", k), 2, 2);
            check($sformatf("bp_in_ready%0d", k + 1), int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        expect_beat("bp_release", 3, 3);
        step();
        expect_beat("pre_sparse", 4, 4);

        // Sparse RR with wrap, last_gnt=4
        in_valid = 6'b010010;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_beat($sformatf("sparse%0d", k), exp_sp[k], exp_sp[k]);
        end

        // FIXED mode select
        rr_mode  = 1'b0;
        sel      = 3'd3;
        in_data  = 24'h54A210;
        in_valid = 6'b001000;
        #1;
        check("fix_in_ready", int'(in_ready), 6'b001000);
        step();
        expect_beat("fix_beat", 3, 4'hA);
        sel = 3'd6;
        #1;
        check("fix_oor_in_ready", int'(in_ready), 0);
        step();
        check("fix_oor_out_valid", int'(out_valid), 0);
        check("fix_oor_in_ready2", int'(in_ready), 0);

        // Reset mid-transfer
        rr_mode  = 1'b1;
        in_valid = 6'h3F;
        in_data  = 24'h543210;
        step();
        expect_beat("mid_load", 2, 2);
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_ch", int'(out_ch), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rel_in_ready", int'(in_ready), 6'b000001);
        step();
        expect_beat("mid_first", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
